uop_cache_ctrl: RTL and testbench

Controller for the 64-entry x 32-bit `uop_cache` block RAM.
- Holds per-entry valid bits and tags.
- Serves lookups from fetch, with a hit/miss result and the instruction word.
- Accepts fills from the decode/refill path.
- Sequences a full-cache flush sweep.
- Drives the RAM's simple-dual-port read and write sides, with the read port and write port on the same `clk`. Sits between the front end and the RAM instance.

---
 rtl/uop_cache_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_uop_cache_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uop_cache_ctrl.sv
// ---------------------------------------------------------------------------
// uop_cache_ctrl
//
// Controller for the uop_cache block RAM (2^IDX_W entries x DATA_W bits).
// It owns the per-entry valid bits and tags. It serves fetch lookups with a
// one-cycle hit/miss + data response and accepts fills from the refill path.
// It also sequences a full-cache flush sweep. The RAM itself lives outside
// this module. Only its simple-dual-port read/write controls are driven here.
//
// Optional feature macro: UOP_CACHE_CTRL_STATS_EN
//   defined   -> saturating 16-bit hit/miss counters on stat_hits/stat_misses
//   undefined -> no counter logic, both stat ports tied to 0
//
// Ports
//   clk, reset             : single clock, synchronous active-high reset
//   lk_req/lk_pc/lk_ready  : lookup request handshake (index = pc LSBs)
//   lk_rvalid/lk_hit/lk_data : lookup response, one cycle after accept
//   fl_valid/fl_pc/fl_data/fl_ready : fill request handshake
//   flush_req/flush_busy   : flush start and in-progress indication
//   bram_re/bram_raddr     : RAM read port (data returns next cycle)
//   bram_we/bram_waddr/bram_wdata : RAM write port
//   bram_rdata             : RAM read data
//   stat_hits/stat_misses  : response statistics
// ---------------------------------------------------------------------------
module uop_cache_ctrl #(
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    lk_req,
  input  logic [IDX_W+TAG_W-1:0]  lk_pc,
  output logic                    lk_ready,
  output logic                    lk_rvalid,
  output logic                    lk_hit,
  output logic [DATA_W-1:0]       lk_data,
  input  logic                    fl_valid,
  input  logic [IDX_W+TAG_W-1:0]  fl_pc,
  input  logic [DATA_W-1:0]       fl_data,
  output logic                    fl_ready,
  input  logic                    flush_req,
  output logic                    flush_busy,
  output logic                    bram_re,
  output logic [IDX_W-1:0]        bram_raddr,
  output logic                    bram_we,
  output logic [IDX_W-1:0]        bram_waddr,
  output logic [DATA_W-1:0]       bram_wdata,
  input  logic [DATA_W-1:0]       bram_rdata,
  output logic [15:0]             stat_hits,
  output logic [15:0]             stat_misses
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [IDX_W-1:0] CNT_LAST = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic               rvalid_q, hit_q;

  logic [IDX_W-1:0]   lk_idx, fl_idx;
  logic [TAG_W-1:0]   lk_tag, fl_tag;
  logic               is_idle, collide, lk_acc, fl_acc, lk_hit_now;
  logic               sweep_clr;

  assign lk_idx = lk_pc[IDX_W-1:0];
  assign lk_tag = lk_pc[IDX_W+TAG_W-1:IDX_W];
  assign fl_idx = fl_pc[IDX_W-1:0];
  assign fl_tag = fl_pc[IDX_W+TAG_W-1:IDX_W];

  assign is_idle = (state_q == ST_IDLE);

  // Same-index lookup and fill in one cycle: the fill wins and the lookup is
  // held off, so a lookup never races a write to the entry it is reading.
  assign collide = lk_req & fl_valid & (lk_idx == fl_idx);

  // A flush request in IDLE takes the cycle; nothing else is accepted then.
  assign fl_ready = is_idle & ~flush_req;
  assign lk_ready = is_idle & ~flush_req & ~collide;

  assign lk_acc = lk_req & lk_ready;
  assign fl_acc = fl_valid & fl_ready;

  // Tag/valid are read combinationally in the accept cycle; only the data
  // comes back from the RAM a cycle later.
  assign lk_hit_now = valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);

  assign bram_re    = lk_acc;
  assign bram_raddr = lk_acc ? lk_idx : '0;

  assign flush_busy = ~is_idle;
  assign sweep_clr  = ~is_idle;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and RAM write port
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bram_we    = 1'b0;
    bram_waddr = '0;
    bram_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
        end else if (fl_acc) begin
          bram_we    = 1'b1;
          bram_waddr = fl_idx;
          bram_wdata = fl_data;
        end
      end
      ST_FLUSH: begin
        bram_we    = 1'b1;
        bram_waddr = cnt_q;
        bram_wdata = '0;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Valid bits: fills set, the flush sweep clears the entry under cnt.
  // Fills and the sweep are never active in the same cycle.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
      assign valid_d[gi] = (fl_acc && (fl_idx == IDX_W'(gi)))    ? 1'b1 :
                           (sweep_clr && (cnt_q == IDX_W'(gi)))  ? 1'b0 :
                           valid_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tags need no reset: an entry's tag is only consulted while it is valid.
  always_ff @(posedge clk) begin
    if (fl_acc) begin
      tag_q[fl_idx] <= fl_tag;
    end
  end

  // -------------------------------------------------------------------------
  // Lookup response pipeline
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      rvalid_q <= lk_acc;
      hit_q    <= lk_acc & lk_hit_now;
    end
  end

  assign lk_rvalid = rvalid_q;
  assign lk_hit    = rvalid_q & hit_q;
  assign lk_data   = (rvalid_q & hit_q) ? bram_rdata : '0;

  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
`ifdef UOP_CACHE_CTRL_STATS_EN
  logic [15:0] hits_q, hits_d;
  logic [15:0] misses_q, misses_d;
  logic        flush_start;

  // Counters restart from zero whenever a flush begins.
  assign flush_start = is_idle & flush_req;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (flush_start) begin
      hits_d   = '0;
      misses_d = '0;
    end else if (rvalid_q) begin
      if (hit_q) begin
        if (hits_q != 16'hFFFF) hits_d = hits_q + 16'd1;
      end else begin
        if (misses_q != 16'hFFFF) misses_d = misses_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_uop_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uop_cache_ctrl
//
// Directed bench for uop_cache_ctrl with a behavioural RAM attached. Lookups
// push their hand-computed response into a queue when accepted; a separate
// monitor pops and compares whenever lk_rvalid is seen.
// Honours UOP_CACHE_CTRL_STATS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_uop_cache_ctrl;

`ifdef UOP_CACHE_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        lk_req;
  logic [13:0] lk_pc;
  logic        lk_ready, lk_rvalid, lk_hit;
  logic [31:0] lk_data;
  logic        fl_valid;
  logic [13:0] fl_pc;
  logic [31:0] fl_data;
  logic        fl_ready;
  logic        flush_req, flush_busy;
  logic        bram_re, bram_we;
  logic [5:0]  bram_raddr, bram_waddr;
  logic [31:0] bram_wdata, bram_rdata;
  logic [15:0] stat_hits, stat_misses;

  int checks = 0;
  int errors = 0;
  bit quiet  = 1'b0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  uop_cache_ctrl #(.IDX_W(6), .TAG_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .lk_req(lk_req), .lk_pc(lk_pc), .lk_ready(lk_ready),
    .lk_rvalid(lk_rvalid), .lk_hit(lk_hit), .lk_data(lk_data),
    .fl_valid(fl_valid), .fl_pc(fl_pc), .fl_data(fl_data), .fl_ready(fl_ready),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .bram_re(bram_re), .bram_raddr(bram_raddr),
    .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  // Behavioural simple-dual-port RAM with registered read.
  logic [31:0] ram [64];
  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'hBAD0_0000 + 32'(i);
    bram_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (bram_we) ram[bram_waddr] <= bram_wdata;
    if (bram_re) bram_rdata <= ram[bram_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (lk_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lk_unexpected actual=rvalid required=no_response t=%0t", $time);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("lk_hit", 32'(lk_hit), 32'(e[32]));
        chk("lk_data", lk_data, e[31:0]);
        if (!quiet) $display("resp hit=%0d data=%h (exp hit=%0d data=%h)", lk_hit, lk_data, e[32], e[31:0]);
      end
    end
  end

  // One cycle of stimulus: optional lookup and/or fill, with expected
  // handshake results and the expected lookup response.
  task automatic cyc(input bit do_lk, input logic [13:0] lpc,
                     input bit do_fl, input logic [13:0] fpc, input logic [31:0] fdata,
                     input bit e_lkr, input bit e_flr,
                     input bit e_hit, input logic [31:0] e_data);
    lk_req = do_lk; lk_pc = lpc;
    fl_valid = do_fl; fl_pc = fpc; fl_data = fdata;
    @(negedge clk);
    if (do_lk) begin
      chk("lk_ready", 32'(lk_ready), 32'(e_lkr));
      if (lk_ready) begin
        exp_q.push_back({e_hit, e_data});
        chk("bram_re", 32'(bram_re), 32'd1);
        chk("bram_raddr", 32'(bram_raddr), 32'(lpc[5:0]));
      end
    end
    if (do_fl) begin
      chk("fl_ready", 32'(fl_ready), 32'(e_flr));
      if (fl_ready) begin
        chk("bram_we", 32'(bram_we), 32'd1);
        chk("bram_waddr", 32'(bram_waddr), 32'(fpc[5:0]));
        chk("bram_wdata", bram_wdata, fdata);
        if (!quiet) $display("fill pc=%h data=%h", fpc, fdata);
      end
    end
    if (do_lk && !quiet) $display("lookup pc=%h ready=%0d", lpc, lk_ready);
    @(posedge clk); #1;
    lk_req = 1'b0; fl_valid = 1'b0;
  endtask

  task automatic lookup(input logic [13:0] pc, input bit e_hit, input logic [31:0] e_data);
    cyc(1'b1, pc, 1'b0, 14'h0, 32'h0, 1'b1, 1'b1, e_hit, e_data);
  endtask

  task automatic fill(input logic [13:0] pc, input logic [31:0] d);
    cyc(1'b0, 14'h0, 1'b1, pc, d, 1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic check_stats(input logic [15:0] eh, input logic [15:0] em);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stat_hits", 32'(stat_hits), 32'(eh));
    chk("stat_misses", 32'(stat_misses), 32'(em));
    chk("idle_bram_re", 32'(bram_re), 32'd0);
    chk("idle_bram_we", 32'(bram_we), 32'd0);
    @(posedge clk); #1;
  endtask

  // Watchdog.
  initial begin
    #950000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; lk_req = 1'b0; lk_pc = '0; fl_valid = 1'b0; fl_pc = '0;
    fl_data = '0; flush_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_lk_ready", 32'(lk_ready), 32'd1);
    chk("rst_fl_ready", 32'(fl_ready), 32'd1);
    chk("rst_flush_busy", 32'(flush_busy), 32'd0);
    chk("rst_lk_rvalid", 32'(lk_rvalid), 32'd0);
    chk("rst_lk_data", lk_data, 32'd0);
    chk("rst_bram_we", 32'(bram_we), 32'd0);
    chk("rst_stat_hits", 32'(stat_hits), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Cold lookup.
    lookup(14'h0105, 1'b0, 32'h0);
    check_stats(16'd0, STATS ? 16'd1 : 16'd0);

    // Fill then hit, then same index with another tag.
    fill(14'h0105, 32'hDEADBEEF);
    lookup(14'h0105, 1'b1, 32'hDEADBEEF);
    lookup(14'h0205, 1'b0, 32'h0);

    // Collision: fill wins, lookup retried next cycle.
    cyc(1'b1, 14'h0007, 1'b1, 14'h0007, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h0);
    lookup(14'h0007, 1'b1, 32'h12345678);

    // Concurrent fill and lookup on different indices.
    cyc(1'b1, 14'h0105, 1'b1, 14'h0F3F, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
    lookup(14'h0F3F, 1'b1, 32'hCAFEF00D);
    check_stats(STATS ? 16'd4 : 16'd0, STATS ? 16'd2 : 16'd0);

    // Flush with a response in flight and a fill/lookup in the start cycle.
    lookup(14'h0105, 1'b1, 32'hDEADBEEF);
    flush_req = 1'b1;
    lk_req = 1'b1; lk_pc = 14'h0F3F;
    fl_valid = 1'b1; fl_pc = 14'h0011; fl_data = 32'h55AA55AA;
    @(negedge clk);
    chk("flreq_lk_ready", 32'(lk_ready), 32'd0);
    chk("flreq_fl_ready", 32'(fl_ready), 32'd0);
    chk("flreq_bram_re", 32'(bram_re), 32'd0);
    @(posedge clk); #1;
    flush_req = 1'b0; lk_req = 1'b0; fl_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (flush_busy !== 1'b1) break;
      chk("sweep_we", 32'(bram_we), 32'd1);
      chk("sweep_waddr", 32'(bram_waddr), 32'(n));
      chk("sweep_wdata", bram_wdata, 32'd0);
      chk("sweep_lk_ready", 32'(lk_ready), 32'd0);
      n++;
      @(posedge clk); #1;
      flush_req = (n == 10);   // ignored while sweeping
    end
    flush_req = 1'b0;
    $display("flush busy_cycles=%0d", n);
    chk("flush_busy_cycles", 32'(n), 32'd64);
    chk("post_flush_lk_ready", 32'(lk_ready), 32'd1);
    chk("post_flush_fl_ready", 32'(fl_ready), 32'd1);
    chk("post_flush_hits", 32'(stat_hits), 32'd0);
    chk("post_flush_misses", 32'(stat_misses), 32'd0);
    @(posedge clk); #1;
    lookup(14'h0105, 1'b0, 32'h0);
    lookup(14'h0007, 1'b0, 32'h0);
    lookup(14'h0F3F, 1'b0, 32'h0);
    lookup(14'h0011, 1'b0, 32'h0);

    // Reset in the middle of a sweep.
    fill(14'h0010, 32'h11111111);
    fill(14'h0130, 32'h22222222);
    fill(14'h0005, 32'h33333333);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (flush_busy === 1'b1 && bram_waddr == 6'd20) begin
        n = 1;
        reset = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("sweep_reached_20", 32'(n), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(flush_busy), 32'd0);
    chk("rst_mid_lk_ready", 32'(lk_ready), 32'd1);
    chk("rst_mid_fl_ready", 32'(fl_ready), 32'd1);
    chk("rst_mid_bram_we", 32'(bram_we), 32'd0);
    @(posedge clk); #1;
    lookup(14'h0010, 1'b0, 32'h0);
    lookup(14'h0130, 1'b0, 32'h0);
    lookup(14'h0005, 1'b0, 32'h0);
    lookup(14'h0105, 1'b0, 32'h0);
    fill(14'h0130, 32'h0BADCAFE);
    lookup(14'h0130, 1'b1, 32'h0BADCAFE);
    check_stats(STATS ? 16'd1 : 16'd0, STATS ? 16'd4 : 16'd0);

`ifdef UOP_CACHE_CTRL_STATS_EN
    // Saturation: back-to-back hits well past 16 bits.
    quiet = 1'b1;
    for (int i = 0; i < 65540; i++) lookup(14'h0130, 1'b1, 32'h0BADCAFE);
    quiet = 1'b0;
    check_stats(16'hFFFF, 16'd4);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
